// File: rtl/spio_spinnaker_link_pkt_arbiter_pkg.sv
// Shared SpiNNaker link packet definitions used by the receiver, the transmitter
// and the packet arbiter.
package spio_spinnaker_link_pkt_arbiter_pkg;

    localparam int PKT_BITS = 72;

    // Field ranges expressed as (lsb +: width) pairs.
    localparam int PKT_HDR_LSB = 0;
    localparam int PKT_HDR_W   = 8;
    localparam int PKT_KEY_LSB = 8;
    localparam int PKT_KEY_W   = 32;
    localparam int PKT_PLD_LSB = 40;
    localparam int PKT_PLD_W   = 32;

    typedef logic [PKT_BITS-1:0] pkt_bits_t;

    // Packed view of a packet; member order matches the field ranges above.
    typedef struct packed {
        logic [PKT_PLD_W-1:0] pld;
        logic [PKT_KEY_W-1:0] key;
        logic [PKT_HDR_W-1:0] hdr;
    } pkt_t;

    // Increment a port index with explicit wrap, since the port count need
    // not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_pkt_arbiter_if.sv
// Packet bus between the link receivers, the arbiter and the downstream consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface spio_spinnaker_link_pkt_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_BITS  = 2
);

    logic [spio_spinnaker_link_pkt_arbiter_pkg::PKT_BITS*NUM_PORTS-1:0] PKT_DATA_IN;
    logic [NUM_PORTS-1:0]                                               PKT_VLD_IN;
    logic [NUM_PORTS-1:0]                                               PKT_RDY_OUT;
    logic [spio_spinnaker_link_pkt_arbiter_pkg::PKT_BITS-1:0]           PKT_DATA_OUT;
    logic                                                               PKT_VLD_OUT;
    logic                                                               PKT_RDY_IN;
    logic [PTR_BITS-1:0]                                                PKT_SRC_OUT;

    modport slave (
        input  PKT_DATA_IN,
        input  PKT_VLD_IN,
        input  PKT_RDY_IN,
        output PKT_RDY_OUT,
        output PKT_DATA_OUT,
        output PKT_VLD_OUT,
        output PKT_SRC_OUT
    );

    modport master (
        output PKT_DATA_IN,
        output PKT_VLD_IN,
        output PKT_RDY_IN,
        input  PKT_RDY_OUT,
        input  PKT_DATA_OUT,
        input  PKT_VLD_OUT,
        input  PKT_SRC_OUT
    );

endinterface

// File: rtl/spio_spinnaker_link_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, else the
// first requester below ptr.
module spio_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_BITS-1:0]  ptr_i,
    output logic [PTR_BITS-1:0]  grant_o,
    output logic                 any_req_o
);

    logic                hi_vld;
    logic                lo_vld;
    logic [PTR_BITS-1:0] hi_idx;
    logic [PTR_BITS-1:0] lo_idx;

    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned (which would infer a latch); blocking assignments are used here
    // because later loop iterations must see earlier ones.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan: the last hit is the lowest index in each half.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (PTR_BITS'(i) >= ptr_i) begin
                    hi_vld = 1'b1;
                    hi_idx = PTR_BITS'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = PTR_BITS'(i);
                end
            end
        end
    end

    assign grant_o   = hi_vld ? hi_idx : lo_idx;
    assign any_req_o = hi_vld | lo_vld;

endmodule

// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
// Round-robin merge of NUM_PORTS link packet streams onto one registered output,
// one whole packet per grant and up to one packet per clock.
module spio_spinnaker_link_pkt_arbiter
    import spio_spinnaker_link_pkt_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic                                                  CLK_IN,
    input  logic                                                  RESET_IN,
    spio_spinnaker_link_pkt_arbiter_if.slave                      pkt_if
);

    logic [PTR_BITS-1:0]  ptr_q;
    logic [PTR_BITS-1:0]  ptr_d;
    logic                 vld_q;
    logic                 vld_d;
    pkt_t                 data_q;
    pkt_t                 data_d;
    logic [PTR_BITS-1:0]  src_q;
    logic [PTR_BITS-1:0]  src_d;

    logic [PTR_BITS-1:0]  grant;
    logic                 any_req;
    logic                 load;
    logic                 take;
    pkt_t                 pkt_sel;
    logic [NUM_PORTS-1:0] rdy;

    spio_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_BITS  (PTR_BITS)
    ) u_rr_arbiter (
        .req_i     (pkt_if.PKT_VLD_IN),
        .ptr_i     (ptr_q),
        .grant_o   (grant),
        .any_req_o (any_req)
    );

    // The holding register can accept when it is empty or being drained now.
    assign load = !vld_q || pkt_if.PKT_RDY_IN;
    assign take = load && any_req && !RESET_IN;

    // Ready steering and packet mux share the same grant decode.
    always_comb begin
        rdy     = '0;
        pkt_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == PTR_BITS'(i)) begin
                rdy[i]  = take;
                pkt_sel = pkt_if.PKT_DATA_IN[i*PKT_BITS +: PKT_BITS];
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        src_d  = src_q;
        ptr_d  = ptr_q;
        if (load) begin
            if (any_req) begin
                vld_d  = 1'b1;
                data_d = pkt_sel;
                src_d  = grant;
                ptr_d  = PTR_BITS'(wrap_inc(int'(grant), NUM_PORTS));
            end else begin
                vld_d  = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is synchronous, so it lives inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            src_q  <= src_d;
            ptr_q  <= ptr_d;
        end
    end

    assign pkt_if.PKT_RDY_OUT  = rdy;
    assign pkt_if.PKT_DATA_OUT = data_q;
    assign pkt_if.PKT_VLD_OUT  = vld_q;
    assign pkt_if.PKT_SRC_OUT  = src_q;

    rdy_onehot_a : assert property (@(posedge CLK_IN) $onehot0(rdy));
    rdy_reset_a  : assert property (@(posedge CLK_IN) RESET_IN |-> (rdy == '0));

endmodule

// File: doc/spio_spinnaker_link_pkt_arbiter.md
# spio_spinnaker_link_pkt_arbiter

Round-robin arbiter that merges the 72-bit packet streams of `NUM_PORTS` SpiNNaker link receivers onto one outgoing packet interface. It sits between the per-link receivers and the downstream packet consumer (switch or host interface), so they share a single packet path. Each grant moves exactly one whole packet; the output is registered and sustains one packet per clock.

## Interface
- `NUM_PORTS`, default 4: number of requesting packet interfaces, range 2..8.
- `PTR_BITS`, default 2: width of the source index, equal to clog2(`NUM_PORTS`).
- `CLK_IN`  in  1  block clock; all state changes on the rising edge.
- `RESET_IN`  in  1  synchronous, active-high reset.
- `PKT_DATA_IN`  in  72×`NUM_PORTS`  input packets; port i occupies bits [72·i +: 72].
- `PKT_VLD_IN`  in  `NUM_PORTS`  per-port packet valid.
- `PKT_RDY_OUT`  out  `NUM_PORTS`  per-port ready, one-hot or zero.
- `PKT_DATA_OUT`  out  72  registered output packet.
- `PKT_VLD_OUT`  out  1  output packet valid.
- `PKT_RDY_IN`  in  1  downstream ready.
- `PKT_SRC_OUT`  out  `PTR_BITS`  index of the port that supplied `PKT_DATA_OUT`.

## Operation
- A transfer happens on an interface at a rising edge where valid and ready are both 1.
- Once valid is asserted on any interface, it stays asserted and its data stays stable until the transfer. The block meets this on its output, and it relies on the receivers to meet it on the inputs.
- One output holding register: `PKT_DATA_OUT`, `PKT_SRC_OUT`, `PKT_VLD_OUT`.
- `load` = `!PKT_VLD_OUT || PKT_RDY_IN`, meaning the register is empty or is being drained this cycle.
- Priority pointer `ptr`:
  - Search order is `ptr`, `ptr+1`, …, `NUM_PORTS-1`, 0, …, `ptr-1`.
  - The first port with `PKT_VLD_IN` set wins and becomes `grant`.
- `PKT_RDY_OUT[grant]` = `load`; all other bits are 0. With no valid input, all bits are 0.
- On an edge with `load` and a grant:
  - the register captures the granted packet and sets `PKT_SRC_OUT` = `grant` and `PKT_VLD_OUT` = 1;
  - `ptr` becomes (`grant`+1) mod `NUM_PORTS`. Wrap is explicit, because `NUM_PORTS` need not be a power of 2.
- On an edge with `load` and no grant: `PKT_VLD_OUT` goes to 0, and data and source hold their values.
- Without `load`, everything holds.
- The block never modifies the packet: no header, key, payload or parity rewriting.
- The block performs no packet counting, no dropping and no parity checking.

## Timing
- Reset values:
  - `PKT_VLD_OUT` = 0;
  - `PKT_DATA_OUT` = 0;
  - `PKT_SRC_OUT` = 0;
  - `ptr` = 0;
  - `PKT_RDY_OUT` = 0, because `load` is 1 but no input is granted while reset is asserted.
- Reset mid-operation:
  - the held output packet is discarded;
  - no input transfer completes in a cycle where `RESET_IN` = 1, because `PKT_RDY_OUT` is forced to 0.
- Latency: an input transfer at edge N presents the packet on the output from edge N (visible in cycle N+1).
- Throughput: one packet per cycle when `PKT_RDY_IN` stays at 1.
- Output full and downstream stalled (`PKT_VLD_OUT`=1, `PKT_RDY_IN`=0):
  - `PKT_RDY_OUT` = 0;
  - `ptr` frozen.
- Output drained and a new packet accepted at the same edge: both happen, with no bubble.
- Combinational paths:
  - `PKT_RDY_OUT` depends on `PKT_VLD_IN`, `PKT_RDY_IN`, `PKT_VLD_OUT` and `ptr`;
  - `PKT_VLD_OUT` and `PKT_DATA_OUT` depend on registers only.
- Fairness: each requesting port waits at most `NUM_PORTS`-1 grants.

## Structure
- The shared link header defines:
  - `PKT_BITS` = 72;
  - field ranges `PKT_HDR_RNG` (0 +: 8), `PKT_KEY_RNG` (8 +: 32) and `PKT_PLD_RNG` (40 +: 32).
- These definitions are used by the receiver, the transmitter and this block; no local redefinition.
- Sub-module `spio_rr_arbiter`:
  - parameters `NUM_PORTS` and `PTR_BITS`;
  - inputs: request vector and `ptr`;
  - outputs: `grant` index and `any_req`;
  - purely combinational.
- The top level holds `ptr`, the output register and the ready steering.

## Test plan
- **Reset:** hold `RESET_IN` 3 cycles with all `PKT_VLD_IN`=1 → `PKT_RDY_OUT`=0, `PKT_VLD_OUT`=0, `PKT_SRC_OUT`=0 throughout. The first transfer is port 0, one cycle after release.
- **All ports request continuously, `PKT_RDY_IN`=1:**
  - port i key = 0x0000_0100+i;
  - required: output source sequence 0,1,2,3,0,1,… with `PKT_VLD_OUT` held at 1, and data matching the source port bit-exact, including payload 0xa5a5_a5a5.
- **Sparse requests:**
  - only ports 1 and 3 valid, `ptr`=2 → grant 3, then 1, then 3;
  - single port 2 alone → consecutive grants to 2 with no bubble.
- **Downstream stall:**
  - `PKT_RDY_IN`=0 for 10 cycles with 2 ports valid;
  - required: output data and source frozen, `PKT_RDY_OUT`=0, `ptr` unchanged;
  - on release: one output transfer and a next-port grant at the same edge.
- **Random stimulus:** random valid and ready patterns on `NUM_PORTS`=3 (wrap at a non-power-of-2 count), 10 000 cycles, with a scoreboard of per-port FIFOs.
  - Required: no loss, no duplication, per-port order kept.
  - Required: no port starved beyond 2 grants.
- **Reset mid-stall:** `PKT_VLD_OUT`=1 and `PKT_RDY_IN`=0, then one reset cycle → next cycle `PKT_VLD_OUT`=0, `ptr`=0, and the stalled input packets are still pending at the inputs.
